// File: rtl/exalu_arbiter.sv
// Round-robin arbiter that shares one extended ALU between two requesters and
// sequences its we/busy handshake, returning results or a timeout error.
module exalu_arbiter #(
   parameter int unsigned TIMEOUT       = 64,
   parameter int unsigned BUSY_RISE_MAX = 4
) (
   input  logic         clock,
   input  logic         resetN,
   input  logic [1:0]   reqValid,
   output logic [1:0]   reqReady,
   input  logic [2:0]   reqOp0,
   input  logic [2:0]   reqOp1,
   input  logic [255:0] reqD1_0,
   input  logic [255:0] reqD1_1,
   input  logic [255:0] reqD2_0,
   input  logic [255:0] reqD2_1,
   output logic [1:0]   rspValid,
   output logic         rspErr,
   output logic [255:0] rspData,
   output logic         exaluWe,
   output logic [2:0]   exaluControl,
   output logic [255:0] exaluD1,
   output logic [255:0] exaluD2,
   input  logic [255:0] exaluOut,
   input  logic         exaluBusy
);

   localparam int unsigned DW = 256;
   localparam int unsigned CW = $clog2(TIMEOUT + 2);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t        state_q, state_d;
   logic          owner_q, owner_d;
   logic          last_q, last_d;
   logic          saw_q, saw_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    ctl_q, ctl_d;
   logic [DW-1:0] d1_q, d1_d;
   logic [DW-1:0] d2_q, d2_d;
   logic [DW-1:0] data_q, data_d;
   logic          err_q, err_d;

   logic          grant_c;
   logic          gidx_c;
   logic          aes_c;
   logic [CW-1:0] cnt_inc_c;

   assign aes_c     = (ctl_q == 3'd1) || (ctl_q == 3'd2);
   assign cnt_inc_c = cnt_q + CW'(1);

   // Next-state logic; grant is decided combinationally so reqReady answers in the same cycle.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      saw_d   = saw_q;
      cnt_d   = cnt_q;
      ctl_d   = ctl_q;
      d1_d    = d1_q;
      d2_d    = d2_q;
      data_d  = data_q;
      err_d   = err_q;
      grant_c = 1'b0;
      gidx_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!exaluBusy && (reqValid != 2'b00)) begin
               grant_c = 1'b1;
               gidx_c  = (reqValid == 2'b11) ? ~last_q : reqValid[1];
               ctl_d   = gidx_c ? reqOp1  : reqOp0;
               d1_d    = gidx_c ? reqD1_1 : reqD1_0;
               d2_d    = gidx_c ? reqD2_1 : reqD2_0;
               owner_d = gidx_c;
               last_d  = gidx_c;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (aes_c) begin
               cnt_d   = '0;
               saw_d   = 1'b0;
               state_d = WAIT;
            end else begin
               data_d  = exaluOut;
               err_d   = 1'b0;
               state_d = DONE;
            end
         end
         WAIT: begin
            if (exaluBusy) saw_d = 1'b1;
            if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_inc_c;
            if (saw_q && !exaluBusy) begin
               data_d  = exaluOut;
               err_d   = 1'b0;
               state_d = DONE;
            end else if ((!saw_q && !exaluBusy && (cnt_inc_c >= CW'(BUSY_RISE_MAX))) ||
                         (cnt_inc_c >= CW'(TIMEOUT))) begin
               data_d  = '0;
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // lastGrant resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         saw_q   <= 1'b0;
         cnt_q   <= '0;
         ctl_q   <= '0;
         d1_q    <= '0;
         d2_q    <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         saw_q   <= saw_d;
         cnt_q   <= cnt_d;
         ctl_q   <= ctl_d;
         d1_q    <= d1_d;
         d2_q    <= d2_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   // we follows busy in WAIT so it drops the same cycle busy falls and the exalu never restarts.
   assign exaluWe      = (state_q == ISSUE) || ((state_q == WAIT) && exaluBusy);
   assign reqReady     = grant_c ? (gidx_c ? 2'b10 : 2'b01) : 2'b00;
   assign rspValid     = (state_q == DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign rspErr       = err_q;
   assign rspData      = data_q;
   assign exaluControl = ctl_q;
   assign exaluD1      = d1_q;
   assign exaluD2      = d2_q;

endmodule

// File: tb/tb_exalu_arbiter.sv
// Directed and randomized bench for exalu_arbiter with a behavioural exalu and
// a transaction-level reference for grants and responses.
module tb_exalu_arbiter;

   localparam int unsigned TIMEOUT       = 64;
   localparam int unsigned BUSY_RISE_MAX = 4;
   localparam logic [255:0] PT  = 256'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f;
   localparam logic [255:0] CT  = 256'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clock = 1'b0;
   logic         resetN;
   logic [1:0]   reqValid, reqReady, rspValid;
   logic [2:0]   reqOp0, reqOp1, exaluControl;
   logic [255:0] reqD1_0, reqD1_1, reqD2_0, reqD2_1;
   logic         rspErr, exaluWe, exaluBusy;
   logic [255:0] rspData, exaluD1, exaluD2, exaluOut;

   int n_vec = 0;
   int n_err = 0;

   // exalu model controls: 0 normal, 1 busy held low, 2 busy sticks high once started, 3 busy forced high
   int           mode     = 1;
   int           busy_len = 10;
   int           mrem     = 0;
   logic         mbusy    = 1'b0;
   logic [255:0] mres     = '0;

   exalu_arbiter #(.TIMEOUT(TIMEOUT), .BUSY_RISE_MAX(BUSY_RISE_MAX)) dut (
      .clock(clock), .resetN(resetN),
      .reqValid(reqValid), .reqReady(reqReady),
      .reqOp0(reqOp0), .reqOp1(reqOp1),
      .reqD1_0(reqD1_0), .reqD1_1(reqD1_1), .reqD2_0(reqD2_0), .reqD2_1(reqD2_1),
      .rspValid(rspValid), .rspErr(rspErr), .rspData(rspData),
      .exaluWe(exaluWe), .exaluControl(exaluControl),
      .exaluD1(exaluD1), .exaluD2(exaluD2),
      .exaluOut(exaluOut), .exaluBusy(exaluBusy)
   );

   always #5 clock = ~clock;

   function automatic logic [255:0] ref_out(input logic [2:0] op, input logic [255:0] a, input logic [255:0] b);
      case (op)
         3'd1: return (a == PT && b == KEY) ? CT : (a ^ {b[127:0], b[255:128]} ^ 256'(op));
         3'd2: return (a == CT && b == KEY) ? PT : (a ^ {b[127:0], b[255:128]} ^ 256'(op));
         3'd3: return a >> b[7:0];
         3'd5: return {a[247:0], b[7:0]};
         3'd6: return a << b[7:0];
         default: return '0;
      endcase
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   always @(posedge clock) begin
      case (mode)
         1: mbusy <= 1'b0;
         3: mbusy <= 1'b1;
         default: begin
            if (!mbusy) begin
               if (exaluWe && (exaluControl == 3'd1 || exaluControl == 3'd2)) begin
                  mbusy <= 1'b1;
                  mrem  <= busy_len;
               end
            end else if (mode == 0) begin
               if (mrem <= 1) begin
                  mbusy <= 1'b0;
                  mres  <= ref_out(exaluControl, exaluD1, exaluD2);
               end else begin
                  mrem <= mrem - 1;
               end
            end
         end
      endcase
   end

   assign exaluBusy = mbusy;
   assign exaluOut  = (exaluControl == 3'd1 || exaluControl == 3'd2) ? mres
                                                                      : ref_out(exaluControl, exaluD1, exaluD2);

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_i(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input int r, input logic [2:0] op, input logic [255:0] d1, input logic [255:0] d2);
      if (r == 0) begin reqOp0 = op; reqD1_0 = d1; reqD2_0 = d2; end
      else        begin reqOp1 = op; reqD1_1 = d1; reqD2_1 = d2; end
   endtask

   // One request from one requester; returns cycles from grant to rspValid and we activity.
   task automatic send(input int r, input logic [2:0] op, input logic [255:0] d1, input logic [255:0] d2,
                       input int max_cyc, output int lat, output int we_cnt, output int we_bad);
      logic seen;
      @(negedge clock);
      drive(r, op, d1, d2);
      reqValid = (r == 0) ? 2'b01 : 2'b10;
      #1;
      chk_i("grant_ready", int'(reqReady), (r == 0) ? 1 : 2);
      lat = 0; we_cnt = 0; we_bad = 0; seen = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clock);
         reqValid = 2'b00;
         #1;
         lat++;
         if (exaluBusy) seen = 1'b1;
         if (seen && !exaluBusy && exaluWe) we_bad++;
         if (exaluWe) we_cnt++;
         if (rspValid != 2'b00) break;
      end
      chk_i("rsp_owner", int'(rspValid), (r == 0) ? 1 : 2);
   endtask

   initial begin
      int lat, wc, wb;
      int g[4];
      int ngr, nrsp, gcyc, busy_grant;
      logic [1:0] pend;
      logic [2:0] pop[2];
      logic [255:0] pd1[2], pd2[2];
      logic outstanding, owner, last_w, win;
      logic [255:0] expd;
      logic [1:0] exp_ready;
      int age, ntx;

      resetN = 1'b0; reqValid = 2'b00;
      drive(0, 3'd0, '0, '0);
      drive(1, 3'd0, '0, '0);
      repeat (2) @(negedge clock);
      #1;
      chk_i("rst_ready", int'(reqReady), 0);
      chk_i("rst_rspvalid", int'(rspValid), 0);
      chk_i("rst_rsperr", int'(rspErr), 0);
      chk("rst_rspdata", rspData, '0);
      chk_i("rst_we", int'(exaluWe), 0);
      chk_i("rst_ctl", int'(exaluControl), 0);
      chk("rst_d1", exaluD1, '0);
      @(negedge clock);
      resetN = 1'b1; mode = 0; busy_len = 10;

      // single-cycle shift, requester 0
      send(0, 3'd3, 256'hdeadbeef_00000000, 256'd32, 10, lat, wc, wb);
      chk_i("shift_lat", lat, 2);
      chk("shift_data", rspData, 256'hdeadbeef);
      chk_i("shift_err", int'(rspErr), 0);
      @(negedge clock); #1;
      chk_i("shift_rsp_pulse", int'(rspValid), 0);
      chk("hold_d1", exaluD1, 256'hdeadbeef_00000000);

      // byte load, requester 1
      send(1, 3'd5, 256'h12, 256'h1ab, 10, lat, wc, wb);
      chk("bload_data", rspData, 256'h12ab);
      chk_i("bload_lat", lat, 2);

      // contention: both held for four transactions
      @(negedge clock);
      drive(0, 3'd3, 256'h1234_5678_9abc_def0_0000, 256'd8);
      drive(1, 3'd3, 256'hcafe_f00d_0000_0000_0000, 256'd16);
      reqValid = 2'b11;
      ngr = 0; nrsp = 0; gcyc = -10; busy_grant = 0;
      for (int c = 0; c < 40 && nrsp < 4; c++) begin
         if (c > 0) @(negedge clock);
         if (ngr == 4) reqValid = 2'b00;
         #1;
         if (rspValid != 2'b00) begin
            chk_i("cont_rsp_owner", int'(rspValid), (g[nrsp] == 0) ? 1 : 2);
            chk("cont_rsp_data", rspData, (g[nrsp] == 0) ? 256'h1234_5678_9abc_def0_0000 >> 8
                                                         : 256'hcafe_f00d_0000_0000_0000 >> 16);
            nrsp++;
         end
         if (reqReady != 2'b00) begin
            if (ngr > nrsp) busy_grant++;
            if (ngr > 0) chk_i("cont_gap", c - gcyc, 3);
            if (ngr < 4) g[ngr] = reqReady[1] ? 1 : 0;
            gcyc = c;
            ngr++;
         end
      end
      for (int k = 0; k < 4; k++) chk_i($sformatf("cont_grant%0d", k), g[k], k % 2);
      chk_i("cont_ready_while_active", busy_grant, 0);
      chk_i("cont_count", nrsp, 4);

      // AES encrypt then decrypt
      send(0, 3'd1, PT, KEY, 60, lat, wc, wb);
      chk("aes_enc_data", rspData, CT);
      chk_i("aes_enc_err", int'(rspErr), 0);
      chk_i("aes_enc_lat", lat, busy_len + 3);
      chk_i("aes_enc_we_cycles", wc, busy_len + 1);
      chk_i("aes_enc_we_after_busy", wb, 0);
      send(0, 3'd2, CT, KEY, 60, lat, wc, wb);
      chk("aes_dec_data", rspData, PT);
      chk_i("aes_dec_we_after_busy", wb, 0);

      // busy never rises
      mode = 1;
      send(0, 3'd1, PT, KEY, 20, lat, wc, wb);
      chk_i("rise_lat", lat, BUSY_RISE_MAX + 2);
      chk_i("rise_err", int'(rspErr), 1);
      chk("rise_data", rspData, '0);

      // busy stuck high once started
      mode = 2;
      send(1, 3'd1, PT, KEY, 100, lat, wc, wb);
      chk_i("stuck_lat", lat, TIMEOUT + 2);
      chk_i("stuck_err", int'(rspErr), 1);
      chk("stuck_data", rspData, '0);
      reqValid = 2'b01;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock); #1;
         chk_i("stuck_no_grant", int'(reqReady), 0);
      end
      @(negedge clock);
      reqValid = 2'b00; mode = 1;
      @(negedge clock);
      mode = 0;
      send(0, 3'd6, 256'h1, 256'd255, 10, lat, wc, wb);
      chk("recover_data", rspData, 256'h1 << 255);
      chk_i("recover_err", int'(rspErr), 0);

      // async reset in the middle of an AES op
      send(0, 3'd5, 256'h77, 256'h1, 10, lat, wc, wb);
      @(negedge clock);
      drive(0, 3'd1, PT, KEY);
      reqValid = 2'b01;
      #1;
      chk_i("mid_grant", int'(reqReady), 1);
      repeat (4) @(negedge clock);
      reqValid = 2'b00; mode = 3;
      #1;
      chk_i("mid_we_before_rst", int'(exaluWe), 1);
      #1 resetN = 1'b0;
      #1;
      chk_i("arst_we", int'(exaluWe), 0);
      chk_i("arst_ready", int'(reqReady), 0);
      chk_i("arst_rspvalid", int'(rspValid), 0);
      chk_i("arst_ctl", int'(exaluControl), 0);
      chk("arst_d1", exaluD1, '0);
      chk("arst_rspdata", rspData, '0);
      @(negedge clock);
      resetN = 1'b1;
      drive(0, 3'd3, 256'hf0, 256'd4);
      reqValid = 2'b01;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk_i("arst_busy_no_grant", int'(reqReady), 0);
         @(negedge clock);
      end
      mode = 1;
      @(negedge clock);
      reqValid = 2'b00; mode = 0;
      send(0, 3'd3, 256'hf0, 256'd4, 10, lat, wc, wb);
      chk("arst_recover_data", rspData, 256'hf);

      // randomized traffic against a transaction-level reference
      last_w = 1'b0; outstanding = 1'b0; owner = 1'b0; expd = '0;
      pend = 2'b00; age = 0; ntx = 0; win = 1'b0;
      for (int i = 0; i < 2; i++) begin pop[i] = '0; pd1[i] = '0; pd2[i] = '0; end
      for (int c = 0; c < 1500 && ntx < 60; c++) begin
         @(negedge clock);
         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               pop[i]  = 3'($urandom_range(0, 7));
               pd1[i]  = rnd256();
               pd2[i]  = rnd256();
            end
         end
         busy_len = $urandom_range(1, 8);
         drive(0, pop[0], pd1[0], pd2[0]);
         drive(1, pop[1], pd1[1], pd2[1]);
         reqValid = pend;
         #1;
         if (outstanding) age++;
         exp_ready = 2'b00;
         if (!outstanding && pend != 2'b00 && !exaluBusy) begin
            win = (pend == 2'b11) ? ~last_w : pend[1];
            exp_ready = win ? 2'b10 : 2'b01;
         end
         chk_i("rnd_ready", int'(reqReady), int'(exp_ready));
         if (rspValid != 2'b00) begin
            chk_i("rnd_rsp_outstanding", int'(outstanding), 1);
            chk_i("rnd_rsp_owner", int'(rspValid), owner ? 2 : 1);
            chk("rnd_rsp_data", rspData, expd);
            chk_i("rnd_rsp_err", int'(rspErr), 0);
            outstanding = 1'b0;
            ntx++;
         end
         if (outstanding && age > 30) begin
            chk_i("rnd_rsp_age", age, 30);
            outstanding = 1'b0;
         end
         if (exp_ready != 2'b00) begin
            outstanding = 1'b1;
            owner = win;
            last_w = win;
            expd = ref_out(pop[win], pd1[win], pd2[win]);
            pend[win] = 1'b0;
            age = 0;
         end
      end
      chk_i("rnd_tx_count", ntx, 60);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
